// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream console front end driving the text RAM system write port.
// Optional HT support is compiled in when CONSOLE_TAB_EN is defined.
`default_nettype none

module text_console_writer #(
   parameter int COLS = 40,
   parameter int ROWS = 25
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [9:0] ram_addr,
   output logic [7:0] ram_data,
   output logic       ram_wren,
   output logic [5:0] cursor_col,
   output logic [4:0] cursor_row,
   output logic       busy
);

   localparam int CELLS = COLS * ROWS;

   typedef enum logic [1:0] {
      S_CLEAR   = 2'd0,
      S_IDLE    = 2'd1,
      S_LINECLR = 2'd2
   } state_t;

   state_t     state_q;
   logic [9:0] clr_idx_q;
   logic [5:0] lc_k_q;
   logic [5:0] col_q;
   logic [4:0] row_q;
   logic [9:0] ram_addr_q;
   logic [7:0] ram_data_q;
   logic       ram_wren_q;

   logic [9:0] w_row_base;
   logic [9:0] w_cur_addr;
   logic [4:0] w_next_row;
   logic [6:0] w_tab;

   assign w_row_base = 10'(row_q) * 10'(COLS);
   assign w_cur_addr = w_row_base + 10'(col_q);
   assign w_next_row = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
   assign w_tab      = {1'b0, col_q[5:3], 3'b000} + 7'd8;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= S_CLEAR;
         clr_idx_q  <= '0;
         lc_k_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         ram_wren_q <= 1'b0;
      end else begin
         ram_wren_q <= 1'b0;
         case (state_q)
            S_CLEAR: begin
               col_q      <= '0;
               row_q      <= '0;
               ram_addr_q <= clr_idx_q;
               ram_data_q <= 8'h20;
               ram_wren_q <= 1'b1;
               if (clr_idx_q == 10'(CELLS - 1)) begin
                  clr_idx_q <= '0;
                  state_q   <= S_IDLE;
               end else begin
                  clr_idx_q <= clr_idx_q + 10'd1;
               end
            end
            // row_q already holds the new row while its line is blanked
            S_LINECLR: begin
               ram_addr_q <= w_row_base + 10'(lc_k_q);
               ram_data_q <= 8'h20;
               ram_wren_q <= 1'b1;
               if (lc_k_q == 6'(COLS - 1)) begin
                  lc_k_q  <= '0;
                  state_q <= S_IDLE;
               end else begin
                  lc_k_q <= lc_k_q + 6'd1;
               end
            end
            S_IDLE: begin
               if (in_valid) begin
                  if (in_data inside {[8'h20:8'h7E]}) begin
                     ram_addr_q <= w_cur_addr;
                     ram_data_q <= in_data;
                     ram_wren_q <= 1'b1;
                     if (col_q == 6'(COLS - 1)) begin
                        col_q   <= '0;
                        row_q   <= w_next_row;
                        lc_k_q  <= '0;
                        state_q <= S_LINECLR;
                     end else begin
                        col_q <= col_q + 6'd1;
                     end
                  end else begin
                     case (in_data)
                        8'h0A: begin
                           col_q   <= '0;
                           row_q   <= w_next_row;
                           lc_k_q  <= '0;
                           state_q <= S_LINECLR;
                        end
                        8'h0D: col_q <= '0;
                        8'h08: begin
                           if (col_q != 6'd0) begin
                              col_q      <= col_q - 6'd1;
                              ram_addr_q <= w_cur_addr - 10'd1;
                              ram_data_q <= 8'h20;
                              ram_wren_q <= 1'b1;
                           end
                        end
                        8'h0C: begin
                           clr_idx_q <= '0;
                           state_q   <= S_CLEAR;
                        end
`ifdef CONSOLE_TAB_EN
                        8'h09: begin
                           if (w_tab >= 7'(COLS)) begin
                              col_q   <= '0;
                              row_q   <= w_next_row;
                              lc_k_q  <= '0;
                              state_q <= S_LINECLR;
                           end else begin
                              col_q <= w_tab[5:0];
                           end
                        end
`endif
                        default: ;
                     endcase
                  end
               end
            end
            default: state_q <= S_CLEAR;
         endcase
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign busy       = !in_ready;
   assign ram_addr   = ram_addr_q;
   assign ram_data   = ram_data_q;
   assign ram_wren   = ram_wren_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer.
`default_nettype none

module tb_text_console_writer;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic [9:0] ram_addr;
   logic [7:0] ram_data;
   logic       ram_wren;
   logic [5:0] cursor_col;
   logic [4:0] cursor_row;
   logic       busy;

   text_console_writer #(.COLS(40), .ROWS(25)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .ram_wren   (ram_wren),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [9:0] wa[$];
   logic [7:0] wd[$];
   int         wc[$];

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(posedge sys_clk) begin
      #1;
      if (ram_wren === 1'b1) begin
         wa.push_back(ram_addr);
         wd.push_back(ram_data);
         wc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
      end
   endtask

   task automatic clrq();
      wa.delete();
      wd.delete();
      wc.delete();
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 5000) begin
         tick(1);
         n++;
      end
      if (n >= 5000) chk("send_timeout", 1, 0);
      tick(1);
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (!in_ready && n < 2000) begin
         n++;
         tick(1);
      end
   endtask

   task automatic blank_run(input string tag, input int first, input int cnt, input int base);
      int e;
      e = 0;
      for (int i = 0; i < cnt; i++)
         if (wa[first+i] !== 10'(base + i) || wd[first+i] !== 8'h20) e++;
      chk(tag, e, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tick(3);
      chk("rst_wren", ram_wren, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_col", cursor_col, 0);
      chk("rst_row", cursor_row, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 1);

      clrq();
      sys_rst_n = 1'b1;
      busy_len(n);
      chk("clr_len", n, 1000);
      tick(2);
      chk("clr_count", wa.size(), 1000);
      if (wa.size() == 1000) blank_run("clr_content", 0, 1000, 0);

      clrq();
      send(8'h41);
      send(8'h42);
      in_valid = 1'b0;
      tick(2);
      chk("ab_count", wa.size(), 2);
      if (wa.size() == 2) begin
         chk("ab_a", {wa[0], wd[0]}, {10'd0, 8'h41});
         chk("ab_b", {wa[1], wd[1]}, {10'd1, 8'h42});
         chk("ab_gap", wc[1] - wc[0], 1);
      end
      chk("ab_col", cursor_col, 2);
      chk("ab_row", cursor_row, 0);

      send(8'h0D);
      clrq();
      for (int i = 0; i < 40; i++) send(8'h30 + 8'(i % 10));
      in_valid = 1'b0;
      busy_len(n);
      chk("wrap_busy", n, 40);
      tick(2);
      chk("wrap_count", wa.size(), 80);
      if (wa.size() == 80) begin
         chk("wrap_last", {wa[39], wd[39]}, {10'd39, 8'h39});
         blank_run("wrap_lineclr", 40, 40, 40);
         chk("wrap_gap", wc[40] - wc[39], 1);
      end
      chk("wrap_col", cursor_col, 0);
      chk("wrap_row", cursor_row, 1);

      for (int i = 0; i < 23; i++) send(8'h0A);
      in_valid = 1'b0;
      busy_len(n);
      chk("lf_row24", cursor_row, 24);
      clrq();
      send(8'h0A);
      send(8'h58);
      in_valid = 1'b0;
      tick(2);
      chk("lfw_count", wa.size(), 41);
      if (wa.size() == 41) begin
         blank_run("lfw_lineclr", 0, 40, 0);
         chk("lfw_x", {wa[40], wd[40]}, {10'd0, 8'h58});
      end
      chk("lfw_row", cursor_row, 0);
      chk("lfw_col", cursor_col, 1);

      send(8'h0D);
      for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
      in_valid = 1'b0;
      tick(1);
      chk("bs_pre_col", cursor_col, 5);
      clrq();
      send(8'h08);
      in_valid = 1'b0;
      tick(2);
      chk("bs_count", wa.size(), 1);
      if (wa.size() == 1) chk("bs_write", {wa[0], wd[0]}, {10'd4, 8'h20});
      chk("bs_col", cursor_col, 4);
      send(8'h0D);
      in_valid = 1'b0;
      tick(1);
      clrq();
      send(8'h08);
      in_valid = 1'b0;
      tick(2);
      chk("bs0_count", wa.size(), 0);
      chk("bs0_col", cursor_col, 0);

      for (int i = 0; i < 3; i++) send(8'h70);
      send(8'h01);
      in_valid = 1'b0;
      tick(2);
      clrq();
      tick(1);
      chk("ign_col", cursor_col, 3);
      send(8'h09);
      in_valid = 1'b0;
      tick(2);
      chk("ht_count", wa.size(), 0);
`ifdef CONSOLE_TAB_EN
      chk("ht_col", cursor_col, 8);
      send(8'h0D);
      for (int i = 0; i < 35; i++) send(8'h7A);
      in_valid = 1'b0;
      tick(1);
      chk("ht35_pre", cursor_col, 35);
      clrq();
      send(8'h09);
      in_valid = 1'b0;
      busy_len(n);
      chk("ht35_busy", n, 40);
      tick(2);
      chk("ht35_count", wa.size(), 40);
      if (wa.size() == 40) blank_run("ht35_lineclr", 0, 40, 40);
      chk("ht35_col", cursor_col, 0);
      chk("ht35_row", cursor_row, 1);
`else
      chk("ht_col", cursor_col, 3);
`endif

      clrq();
      send(8'h0C);
      in_valid = 1'b0;
      busy_len(n);
      chk("ff_busy", n, 1000);
      tick(2);
      chk("ff_count", wa.size(), 1000);
      chk("ff_col", cursor_col, 0);
      chk("ff_row", cursor_row, 0);

      send(8'h0C);
      in_valid = 1'b0;
      tick(10);
      sys_rst_n = 1'b0;
      tick(1);
      chk("mid_rst_wren", ram_wren, 0);
      chk("mid_rst_ready", in_ready, 0);
      clrq();
      sys_rst_n = 1'b1;
      busy_len(n);
      chk("mid_rst_len", n, 1000);
      tick(2);
      chk("mid_rst_count", wa.size(), 1000);
      if (wa.size() == 1000) chk("mid_rst_first", wa[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
